// File: rtl/pcm_frame_pack_pkg.sv
// Shared types and helpers for the PCM frame packer.
// Holds the FIFO entry layout and the frame length decode.
package pcm_frame_pack_pkg;

    localparam int FRAME_LEN_W = 12;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } fifo_entry_t;

    // A programmed length of zero stands for the maximum frame, 4096 words.
    function automatic logic [FRAME_LEN_W:0] frame_len_decode(
        input logic [FRAME_LEN_W-1:0] len
    );
        if (len == '0) begin
            return {1'b1, {FRAME_LEN_W{1'b0}}};
        end
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/pcm_word_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head.
// The head register holds its last value while the FIFO is empty.
module pcm_word_fifo #(
    parameter int W   = 34,
    parameter int FAW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [FAW:0] count_o
);

    localparam int DEPTH = 1 << FAW;
    localparam logic [FAW:0] FULL_CNT = {1'b1, {FAW{1'b0}}};

    logic [W-1:0]   mem_q [DEPTH];
    logic [FAW-1:0] wr_q, wr_d;
    logic [FAW-1:0] rd_q, rd_d;
    logic [FAW:0]   cnt_q, cnt_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = dout_q;

    // A full FIFO still accepts a push when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers, occupancy and the word that will sit at the head.
    always_comb begin
        wr_d   = wr_q + FAW'(do_push);
        rd_d   = rd_q + FAW'(do_pop);
        cnt_d  = cnt_q + (FAW+1)'(do_push) - (FAW+1)'(do_pop);
        dout_d = dout_q;
        if (cnt_d != '0) begin
            if (do_push && (wr_q == rd_d)) begin
                dout_d = din_i;
            end else begin
                dout_d = mem_q[rd_d];
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointer, occupancy and head register update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: rtl/pcm_frame_pack.sv
// Packs sample pairs into 32-bit words, frames them and buffers them.
// Define PCM_FRAME_PACK_HI_FIRST_EN to put the first sample in bits 31:16.
module pcm_frame_pack
    import pcm_frame_pack_pkg::*;
#(
    parameter int FAW = 6,
    parameter int DCW = 16
) (
    input  logic                   pcm_clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic                   pcm_in_valid,
    output logic                   pcm_in_ready,
    input  logic [15:0]            pcm_in,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [31:0]            word_data,
    output logic                   word_sof,
    output logic                   word_eof,
    output logic [FAW:0]           fill_level,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic [DCW-1:0]         drop_cnt
);

    logic                   half_valid_q;
    logic [15:0]            half_data_q;
    logic [FRAME_LEN_W-1:0] word_idx_q;
    logic [FRAME_LEN_W-1:0] len_q;
    logic                   ovf_q;
    logic [DCW-1:0]         drop_cnt_q;

    logic                   form;
    logic                   drop;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FRAME_LEN_W-1:0] len_eff;
    logic [FRAME_LEN_W:0]   len_dec;
    logic                   tag_sof;
    logic                   tag_eof;
    logic [31:0]            packed_word;
    fifo_entry_t            din;
    fifo_entry_t            dout;

    // The FIR stage never stalls, so every offered sample is taken.
    assign pcm_in_ready = 1'b1;

    assign form = enable && pcm_in_valid && half_valid_q;
    assign pop  = word_valid && word_ready;
    assign drop = form && fifo_full && !pop;

`ifdef PCM_FRAME_PACK_HI_FIRST_EN
    assign packed_word = {half_data_q, pcm_in};
`else
    assign packed_word = {pcm_in, half_data_q};
`endif

    // The first word of a frame uses the live length, later ones the latch.
    assign len_eff = (word_idx_q == '0) ? frame_len : len_q;
    assign len_dec = frame_len_decode(len_eff);
    assign tag_sof = (word_idx_q == '0);
    assign tag_eof = ({1'b0, word_idx_q} == (len_dec - 1'b1));

    assign din.data = packed_word;
    assign din.sof  = tag_sof;
    assign din.eof  = tag_eof;

    pcm_word_fifo #(
        .W   ($bits(fifo_entry_t)),
        .FAW (FAW)
    ) u_fifo (
        .clk     (pcm_clk),
        .rst_n   (rst_n),
        .push_i  (form),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_level)
    );

    assign word_valid = !fifo_empty;
    assign word_data  = dout.data;
    assign word_sof   = dout.sof;
    assign word_eof   = dout.eof;
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_cnt_q;

    // Pair assembly and frame position; dropped words still advance framing.
    always_ff @(posedge pcm_clk) begin
        if (!rst_n) begin
            half_valid_q <= 1'b0;
            half_data_q  <= '0;
            word_idx_q   <= '0;
            len_q        <= '0;
        end else if (!enable) begin
            half_valid_q <= 1'b0;
            word_idx_q   <= '0;
        end else if (pcm_in_valid) begin
            if (!half_valid_q) begin
                half_data_q  <= pcm_in;
                half_valid_q <= 1'b1;
            end else begin
                half_valid_q <= 1'b0;
                if (word_idx_q == '0) begin
                    len_q <= frame_len;
                end
                word_idx_q <= tag_eof ? '0 : word_idx_q + 1'b1;
            end
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear.
    always_ff @(posedge pcm_clk) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (ovf_clr) begin
                drop_cnt_q <= drop ? DCW'(1) : '0;
            end else if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcm_frame_pack.sv
// Directed self-checking bench for pcm_frame_pack (FIFO depth 4).
// Define PCM_FRAME_PACK_HI_FIRST_EN to check the high-first packing build.
module tb_pcm_frame_pack;

    logic        pcm_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] frame_len = 12'd0;
    logic        pcm_in_valid = 1'b0;
    logic        pcm_in_ready;
    logic [15:0] pcm_in = 16'd0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic        word_sof;
    logic        word_eof;
    logic [2:0]  fill_level;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic [15:0] drop_cnt;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] sof_exp;
    logic [7:0] eof_exp;

    always #5 pcm_clk = ~pcm_clk;

    pcm_frame_pack #(
        .FAW (2),
        .DCW (16)
    ) dut (
        .pcm_clk      (pcm_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_len    (frame_len),
        .pcm_in_valid (pcm_in_valid),
        .pcm_in_ready (pcm_in_ready),
        .pcm_in       (pcm_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .word_sof     (word_sof),
        .word_eof     (word_eof),
        .fill_level   (fill_level),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr),
        .drop_cnt     (drop_cnt)
    );

    function automatic logic [31:0] pk(input logic [15:0] a, input logic [15:0] b);
`ifdef PCM_FRAME_PACK_HI_FIRST_EN
        return {a, b};
`else
        return {b, a};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pcm_clk);
        #1;
    endtask

    task automatic sample(input logic [15:0] s);
        pcm_in_valid = 1'b1;
        pcm_in = s;
        step();
        pcm_in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_data", word_data, 32'd0);
        chk("rst_sof", 32'(word_sof), 32'd0);
        chk("rst_eof", 32'(word_eof), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ready", 32'(pcm_in_ready), 32'd1);

        // basic packing, frame_len=2
        rst_n = 1'b1;
        enable = 1'b1;
        frame_len = 12'd2;
        word_ready = 1'b1;
        sof_exp = 8'b0000_0101;
        eof_exp = 8'b0000_1010;
        for (int w = 0; w < 4; w++) begin
            sample(16'(2 * w + 1));
            chk("t1_idle", 32'(word_valid), 32'd0);
            sample(16'(2 * w + 2));
            chk("t1_valid", 32'(word_valid), 32'd1);
            chk("t1_data", word_data, pk(16'(2 * w + 1), 16'(2 * w + 2)));
            chk("t1_sof", 32'(word_sof), 32'(sof_exp[w]));
            chk("t1_eof", 32'(word_eof), 32'(eof_exp[w]));
        end
        step();
        chk("t1_drained", 32'(word_valid), 32'd0);
        chk("t1_hold", word_data, pk(16'd7, 16'd8));

        // backpressure and overflow
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        word_ready = 1'b0;
        frame_len = 12'd0;
        for (int i = 0; i < 12; i++) begin
            sample(16'(16'h0010 + i));
        end
        chk("t2_fill", 32'(fill_level), 32'd4);
        chk("t2_ovf", 32'(ovf), 32'd1);
        chk("t2_drop", 32'(drop_cnt), 32'd2);
        chk("t2_sof", 32'(word_sof), 32'd1);
        word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_dvalid", 32'(word_valid), 32'd1);
            chk("t2_ddata", word_data, pk(16'(16'h0010 + 2 * k), 16'(16'h0011 + 2 * k)));
            step();
        end
        chk("t2_empty", 32'(word_valid), 32'd0);
        chk("t2_fill0", 32'(fill_level), 32'd0);

        // ovf_clr, then full with simultaneous pop
        word_ready = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_clr_ovf", 32'(ovf), 32'd0);
        chk("t3_clr_drop", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            sample(16'(16'h0020 + i));
        end
        chk("t3_full", 32'(fill_level), 32'd4);
        sample(16'h0028);
        word_ready = 1'b1;
        sample(16'h0029);
        word_ready = 1'b0;
        chk("t3_fill", 32'(fill_level), 32'd4);
        chk("t3_ovf", 32'(ovf), 32'd0);
        chk("t3_head", word_data, pk(16'h0022, 16'h0023));

        // ovf_clr racing a drop
        sample(16'h0030);
        sample(16'h0031);
        chk("t4_ovf1", 32'(ovf), 32'd1);
        chk("t4_drop1", 32'(drop_cnt), 32'd1);
        sample(16'h0032);
        sample(16'h0033);
        chk("t4_drop2", 32'(drop_cnt), 32'd2);
        sample(16'h0034);
        ovf_clr = 1'b1;
        sample(16'h0035);
        ovf_clr = 1'b0;
        chk("t4_race_ovf", 32'(ovf), 32'd1);
        chk("t4_race_drop", 32'(drop_cnt), 32'd1);
        chk("t4_race_fill", 32'(fill_level), 32'd4);

        // reset mid-drain discards everything
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_rst_fill", 32'(fill_level), 32'd0);
        chk("t5_rst_valid", 32'(word_valid), 32'd0);
        chk("t5_rst_ovf", 32'(ovf), 32'd0);

        // enable drop loses the pending half sample
        frame_len = 12'd4;
        word_ready = 1'b1;
        sample(16'h0001);
        sample(16'h0002);
        sample(16'h0003);
        enable = 1'b0;
        step();
        enable = 1'b1;
        sample(16'h00A1);
        sample(16'h00A2);
        chk("t5_valid", 32'(word_valid), 32'd1);
        chk("t5_data", word_data, pk(16'h00A1, 16'h00A2));
        chk("t5_sof", 32'(word_sof), 32'd1);
        sample(16'h00A3);
        sample(16'h00A4);
        chk("t5_data2", word_data, pk(16'h00A3, 16'h00A4));
        chk("t5_sof2", 32'(word_sof), 32'd0);

        // frame_len change mid-frame
        enable = 1'b0;
        step();
        enable = 1'b1;
        frame_len = 12'd4;
        sof_exp = 8'b0101_0001;
        eof_exp = 8'b1010_1000;
        for (int w = 0; w < 8; w++) begin
            sample(16'(16'h0100 + 2 * w));
            sample(16'(16'h0101 + 2 * w));
            chk("t6_valid", 32'(word_valid), 32'd1);
            chk("t6_sof", 32'(word_sof), 32'(sof_exp[w]));
            chk("t6_eof", 32'(word_eof), 32'(eof_exp[w]));
            if (w == 0) begin
                frame_len = 12'd2;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
